gpio_port: RTL and testbench

//  Parametrised memory-mapped GPIO peripheral, successor to the fixed 4-bit output-only gpio.
//  Per-pin direction control, synchronised inputs, rise/fall edge detection with a sticky,

---
 rtl/gpio_pkg.sv | 27 ++
 rtl/gpio_sync.sv | 31 +++
 rtl/gpio_port.sv | 155 +++++++++++++++
 tb/tb_gpio_port.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO peripheral.
// Register offsets, register width, byte-enable helper.
package gpio_pkg;

  localparam int REG_W = 32;

  localparam logic [2:0] OFF_OUT    = 3'd0;
  localparam logic [2:0] OFF_DIR    = 3'd1;
  localparam logic [2:0] OFF_IN     = 3'd2;
  localparam logic [2:0] OFF_IEN    = 3'd3;
  localparam logic [2:0] OFF_RISE   = 3'd4;
  localparam logic [2:0] OFF_FALL   = 3'd5;
  localparam logic [2:0] OFF_STATUS = 3'd6;

  // Expand 4 byte enables into a 32-bit bit mask.
  function automatic logic [REG_W-1:0] be_mask(
    input logic [3:0] be
  );
    logic [REG_W-1:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage input synchroniser.
// Every stage resets to 0 asynchronously.
module gpio_sync #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_ff [STAGES];

  // Shift pad samples through the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_ff[k] <= '0;
      end
    end else begin
      r_ff[0] <= i_d;
      for (int k = 1; k < STAGES; k++) begin
        r_ff[k] <= r_ff[k-1];
      end
    end
  end

  assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: direction, synced inputs,
// edge capture into W1C status, level interrupt.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int              N_PINS      = 8,
  parameter int              ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h80,
  parameter int              SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  input  logic              we,
  output logic [31:0]       q,
  input  logic [N_PINS-1:0] gpio_i,
  output logic [N_PINS-1:0] gpio_o,
  output logic [N_PINS-1:0] gpio_oe,
  output logic              irq
);

  localparam int N = N_PINS;
  localparam logic [2:0] ARM = 3'(SYNC_STAGES + 1);

  logic [N-1:0] r_out, r_dir, r_ien;
  logic [N-1:0] r_rise, r_fall, r_stat;
  logic [N-1:0] r_prev;
  logic [2:0]   r_arm_cnt;
  logic [31:0]  r_q;
  logic         r_irq;

  logic         w_hit, w_wr, w_armed;
  logic [2:0]   w_off;
  logic [31:0]  w_bm;
  logic [N-1:0] w_wm, w_wd, w_s;
  logic [N-1:0] w_rise_ev, w_fall_ev, w_set, w_clr;
  logic [N-1:0] w_out_n, w_dir_n, w_ien_n;
  logic [N-1:0] w_rise_n, w_fall_n, w_stat_n;
  logic [31:0]  w_rd;
  logic         w_unused;

  gpio_sync #(
    .W      (N),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (gpio_i),
    .o_q (w_s)
  );

  assign w_hit = addr[ADDR_W-1:5] ==
                 BASE_ADDR[ADDR_W-1:5];
  assign w_off = addr[4:2];
  assign w_wr  = we & w_hit;
  assign w_bm  = be_mask(be);
  assign w_wm  = w_bm[N-1:0];
  assign w_wd  = wdata[N-1:0];

  assign w_rise_ev = w_s & ~r_prev;
  assign w_fall_ev = ~w_s & r_prev;
  assign w_armed   = (r_arm_cnt == ARM);
  assign w_set     = w_armed ?
    ((r_rise & w_rise_ev) | (r_fall & w_fall_ev)) :
    '0;

  assign w_unused = &{1'b0, addr[1:0], wdata, w_bm};

  // Byte-masked register updates and W1C status.
  always_comb begin
    w_out_n  = r_out;
    w_dir_n  = r_dir;
    w_ien_n  = r_ien;
    w_rise_n = r_rise;
    w_fall_n = r_fall;
    w_clr    = '0;
    if (w_wr) begin
      case (w_off)
        OFF_OUT:
          w_out_n  = (r_out & ~w_wm) | (w_wd & w_wm);
        OFF_DIR:
          w_dir_n  = (r_dir & ~w_wm) | (w_wd & w_wm);
        OFF_IEN:
          w_ien_n  = (r_ien & ~w_wm) | (w_wd & w_wm);
        OFF_RISE:
          w_rise_n = (r_rise & ~w_wm) | (w_wd & w_wm);
        OFF_FALL:
          w_fall_n = (r_fall & ~w_wm) | (w_wd & w_wm);
        OFF_STATUS:
          w_clr    = w_wd & w_wm;
        default: ;
      endcase
    end
    w_stat_n = (r_stat & ~w_clr) | w_set;
  end

  // Read mux over current register contents.
  always_comb begin
    w_rd = '0;
    if (w_hit) begin
      case (w_off)
        OFF_OUT:    w_rd = REG_W'(r_out);
        OFF_DIR:    w_rd = REG_W'(r_dir);
        OFF_IN:     w_rd = REG_W'(w_s);
        OFF_IEN:    w_rd = REG_W'(r_ien);
        OFF_RISE:   w_rd = REG_W'(r_rise);
        OFF_FALL:   w_rd = REG_W'(r_fall);
        OFF_STATUS: w_rd = REG_W'(r_stat);
        default:    w_rd = '0;
      endcase
    end
  end

  // Register file, edge history, read data, irq.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out  <= '0;
      r_dir  <= '0;
      r_ien  <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_stat <= '0;
      r_prev <= '0;
      r_q    <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_out  <= w_out_n;
      r_dir  <= w_dir_n;
      r_ien  <= w_ien_n;
      r_rise <= w_rise_n;
      r_fall <= w_fall_n;
      r_stat <= w_stat_n;
      r_prev <= w_s;
      r_q    <= w_rd;
      r_irq  <= |(w_stat_n & w_ien_n);
    end
  end

  // Hold off edge capture until the sync chain has settled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arm_cnt <= '0;
    end else if (r_arm_cnt != ARM) begin
      r_arm_cnt <= r_arm_cnt + 3'd1;
    end
  end

  assign q       = r_q;
  assign gpio_o  = r_out;
  assign gpio_oe = r_dir;
  assign irq     = r_irq;

endmodule

// File: tb/tb_gpio_port.sv
// Randomised bench for gpio_port against a
// register-map reference model.
module tb_gpio_port;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [31:0] q;
  logic [7:0]  gpio_i = '0;
  logic [7:0]  gpio_o, gpio_oe;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  m_reg [8];
  logic [7:0]  m_hist [$];
  int          m_edges;
  logic [31:0] m_q;
  logic        m_irq;

  gpio_port #(
    .N_PINS      (8),
    .ADDR_W      (8),
    .BASE_ADDR   (8'h80),
    .SYNC_STAGES (S)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .be      (be),
    .wdata   (wdata),
    .we      (we),
    .q       (q),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_hist = {};
    for (int i = 0; i <= S; i++)
      m_hist.push_back(8'h00);
    m_edges = 0;
    m_q = '0;
    m_irq = 1'b0;
  endtask

  // One clock edge of the register map.
  task automatic model_step();
    logic [7:0]  s_now, prv, set, wm, wd;
    logic [31:0] merged, bm;
    logic        hit;
    logic [2:0]  off;
    logic [31:0] rd;
    s_now = m_hist[S-1];
    prv   = m_hist[S];
    hit   = (addr[7:5] == 3'b100);
    off   = addr[4:2];
    rd    = '0;
    if (hit && off == 3'd2) rd = {24'h0, s_now};
    else if (hit && off != 3'd7)
      rd = {24'h0, m_reg[off]};
    set = '0;
    if (m_edges >= S + 1)
      set = (s_now & ~prv & m_reg[4]) |
            (~s_now & prv & m_reg[5]);
    bm = '0;
    for (int b = 0; b < 4; b++)
      if (be[b]) bm[8*b +: 8] = 8'hFF;
    wm = bm[7:0];
    wd = wdata[7:0];
    if (we && hit) begin
      merged = (wdata & bm) |
               ({24'h0, m_reg[off]} & ~bm);
      if (off inside {3'd0, 3'd1, 3'd3,
                      3'd4, 3'd5})
        m_reg[off] = merged[7:0];
      else if (off == 3'd6)
        m_reg[6] = m_reg[6] & ~(wd & wm);
    end
    m_reg[6] = m_reg[6] | set;
    m_irq = |(m_reg[6] & m_reg[3]);
    m_q = rd;
    m_hist.push_front(gpio_i);
    void'(m_hist.pop_back());
    m_edges++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("q", q, m_q);
    chk("gpio_o", {24'h0, gpio_o}, {24'h0, m_reg[0]});
    chk("gpio_oe", {24'h0, gpio_oe}, {24'h0, m_reg[1]});
    chk("irq", {31'h0, irq}, {31'h0, m_irq});
  endtask

  task automatic wr(input logic [7:0] a,
                    input logic [3:0] b,
                    input logic [31:0] d);
    addr = a; be = b; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    addr = a; we = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    chk("rst_q", q, 32'h0);
    chk("rst_o", {24'h0, gpio_o}, 32'h0);
    chk("rst_oe", {24'h0, gpio_oe}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
  endtask

  initial begin
    model_clear();
    do_reset();

    rd(8'h98);
    chk("status_rst", q, 32'h0);

    wr(8'h80, 4'b0001, 32'h0000_00A5);
    chk("byte0", {24'h0, gpio_o}, 32'hA5);
    wr(8'h80, 4'b0010, 32'h0000_FF00);
    chk("byte1", {24'h0, gpio_o}, 32'hA5);
    wr(8'h00, 4'b1111, 32'hFFFF_FFFF);
    chk("outside", {24'h0, gpio_o}, 32'hA5);

    gpio_i = 8'h01;
    repeat (3) rd(8'h88);
    chk("in_sync", q, 32'h1);
    gpio_i = 8'h00;
    repeat (4) rd(8'h88);
    chk("in_low", q, 32'h0);

    wr(8'h90, 4'b0001, 32'h1);
    wr(8'h8C, 4'b0001, 32'h1);
    gpio_i = 8'h01;
    repeat (4) rd(8'h98);
    chk("rise_st", q, 32'h1);
    chk("rise_irq", {31'h0, irq}, 32'h1);
    gpio_i = 8'h00;
    repeat (4) rd(8'h98);
    chk("fall_keep", q, 32'h1);
    wr(8'h98, 4'b0001, 32'h1);
    chk("clr_irq", {31'h0, irq}, 32'h0);
    rd(8'h98);
    chk("clr_st", q, 32'h0);

    gpio_i = 8'h01;
    repeat (S) rd(8'h98);
    wr(8'h98, 4'b0001, 32'h1);
    rd(8'h98);
    chk("race_st", q, 32'h1);
    chk("race_irq", {31'h0, irq}, 32'h1);

    gpio_i = 8'hFF;
    do_reset();
    wr(8'h90, 4'b0001, 32'hFF);
    repeat (6) rd(8'h98);
    chk("held_st", q, 32'h0);

    addr = 8'h80; be = 4'hF;
    wdata = 32'h5A; we = 1'b1;
    #3;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    we = 1'b0;
    model_clear();
    chk("mid_o", {24'h0, gpio_o}, 32'h0);
    rd(8'h90);
    chk("mid_rise", q, 32'h0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        gpio_i = 8'($urandom);
      if ($urandom_range(0, 99) < 85)
        addr = {3'b100, 5'($urandom)};
      else
        addr = 8'($urandom);
      be = 4'($urandom);
      wdata = $urandom;
      if (addr[4:2] == 3'd6 && $urandom_range(0, 1) == 1)
        wdata[7:0] = 8'h00;
      we = ($urandom_range(0, 1) == 1);
      tick();
      if (i == 200) begin
        we = 1'b0;
        do_reset();
      end
    end
    we = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
